// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential requests
// to a 1-cycle-latency instruction memory, and buffers {instr, pc} pairs in a
// DEPTH-entry circular queue drained by decode. A redirect flushes wrong-path state.
module fetch_queue #(
   parameter int unsigned ADDR_W   = 64,
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         redirect_valid,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         imem_req,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic [INSTR_W-1:0]           imem_rdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INSTR_W-1:0]           out_instr,
   output logic [ADDR_W-1:0]            out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned CR_W  = CNT_W + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);

   localparam logic [CR_W-1:0]   DEPTH_CR = CR_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              req_valid_q, req_valid_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];

   logic [CR_W-1:0]   credit;
   logic              push;
   logic              pop;

   // Circular pointer advance that also handles non-power-of-two depths
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // In-flight request holds a queue slot, so it counts against issue credit
   assign credit   = {1'b0, count_q} + CR_W'(req_valid_q);
   assign imem_req = !reset && !redirect_valid && (credit < DEPTH_CR);
   assign push     = req_valid_q && !redirect_valid;
   assign pop      = (count_q != '0) && out_ready && !redirect_valid;

   assign imem_addr = fetch_pc_q;
   assign out_valid = (count_q != '0);
   assign out_instr = mem_q[rd_ptr_q].instr;
   assign out_pc    = mem_q[rd_ptr_q].pc;
   assign occupancy = count_q;

   // Next-state: issue, response push, head pop; redirect flushes everything
   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      req_valid_d = 1'b0;
      req_pc_d    = req_pc_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      mem_d       = mem_q;

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (imem_req) begin
            req_valid_d = 1'b1;
            req_pc_d    = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + STEP;
         end
         if (push) begin
            mem_d[wr_ptr_q] = '{instr: imem_rdata, pc: req_pc_q};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with synchronous reset; reset overrides redirect
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q  <= RESET_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         req_valid_q <= req_valid_d;
         req_pc_q    <= req_pc_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Queue storage; contents are qualified by count so no reset is needed
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined ARM core. It owns the program counter, issues sequential requests to a fixed 1-cycle-latency instruction memory and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode drains the queue through a valid/ready handshake. A redirect from branch resolution flushes all wrong-path state and restarts fetch at the target.

## Interface
- ADDR_W, 64, PC and memory address width (`WORD`)
- INSTR_W, 32, instruction width (`INSTR_LEN`)
- DEPTH, 4, instruction queue entries; legal values ≥ 2
- RESET_PC, 0, PC loaded on reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush queue and load redirect_pc this cycle
- redirect_pc  in  ADDR_W  redirect target
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address; equals internal fetch PC
- imem_rdata  in  INSTR_W  instruction for the request issued in the previous cycle
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts the head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of head instruction
- occupancy  out  $clog2(DEPTH+1)  current queue entries

## Operation
- State: fetch_pc, in-flight flag req_valid with tag req_pc, circular queue with read/write pointers and count.
- Issue: imem_req = !reset && !redirect_valid && (count + req_valid < DEPTH). Pops in the same cycle earn no credit.
- On issue: req_valid <= 1, req_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP, modulo 2^ADDR_W. Wrap-around is silent.
- If no request is issued, req_valid <= 0.
- Response: when req_valid is set and there is no redirect, {imem_rdata, req_pc} is pushed at the queue tail. Issue credit guarantees the push never overflows.
- Pop: a head entry is removed when out_valid && out_ready && !redirect_valid.
- Push and pop in the same cycle leave count unchanged. out_ready while empty has no effect.
- Redirect, which has priority over everything except reset:
  - count <= 0 and pointers are cleared.
  - req_valid <= 0, so any in-flight response is discarded.
  - fetch_pc <= redirect_pc.
  - imem_req = 0.
  - A valid/ready handshake in the same cycle is void; the consumer discards that instruction.
- out_valid = (count != 0). out_instr and out_pc are driven from the head entry, not bypassed from imem_rdata.
- Reset: fetch_pc <= RESET_PC, count <= 0, pointers <= 0, req_valid <= 0. imem_req is held at 0 during reset cycles. Reset overrides redirect.

## Timing
- Outputs after reset: out_valid=0, occupancy=0, imem_req=0 (during reset), imem_addr=RESET_PC on the first non-reset cycle.
- Fetch latency: a request in cycle t returns data during t+1. The entry is written at the end of t+1 and out_valid is visible in t+2.
- Throughput: one instruction per cycle when out_ready is held high.
- Redirect latency: a redirect in cycle t issues redirect_pc in t+1. The target appears at out_pc in t+3.
- With out_ready=0 from reset, exactly DEPTH requests are issued, then imem_req stays low until a pop occurs.
- imem_req depends combinationally on redirect_valid and reset. All other outputs come from registers.

## Test plan
- Free run: release reset, out_ready=1, memory returns instr=addr[31:0]. Required: imem_addr sequence 0,4,8,…; first out_valid 2 cycles after the first request with out_pc=0; then one instruction per cycle with out_instr==out_pc.
- Backpressure: out_ready=0 from reset, DEPTH=4. Required: exactly 4 requests (0x0–0xC), occupancy saturates at 4, imem_req stays 0. Then set out_ready=1. Required: drain 0x0,0x4,0x8,0xC in order, and requests resume at 0x10 only after the first pop.
- Redirect with in-flight request and 3 queued entries, redirect_pc=0x100. Required: occupancy=0 next cycle, no stale PC is ever output, imem_addr=0x100 in t+1, out_pc=0x100 in t+3, followed by 0x104.
- Redirect while the queue is full and out_ready=1 in the same cycle. Required: head is not counted as a pop, queue is empty next cycle, fetch restarts at the target.
- Wrap: redirect_pc=0xFFFF_FFFF_FFFF_FFFC. Required: out_pc sequence 0xFFFF_FFFF_FFFF_FFFC, then 0x0, then 0x4.
- Mid-run reset with a full queue and a request in flight. Required: out_valid=0 and occupancy=0 next cycle, no push from the in-flight response, first post-reset imem_addr=RESET_PC.
